// File: rtl/led_chaser.sv
// LED chaser: debounced start/pause button, run/pause FSM, four step patterns.
module led_chaser #(
    parameter int unsigned N_LED    = 8,
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned DEB_CYC  = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_i,
    input  logic             stop_i,
    input  logic [1:0]       mode_i,
    output logic [N_LED-1:0] led_o,
    output logic             running_o,
    output logic             step_o
);

    localparam int unsigned TickW = $clog2(TICK_DIV);
    localparam int unsigned DebW  = $clog2(DEB_CYC + 1);
    // Arming needs DEB_CYC real low cycles plus the two reset zeros of the synchroniser.
    localparam int unsigned ArmW  = $clog2(DEB_CYC + 3);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    logic            sync1_q, sync2_q;
    logic            deb_q;
    logic [DebW-1:0] deb_cnt_q;
    logic            armed_q;
    logic [ArmW-1:0] arm_cnt_q;

    state_e             state_q;
    logic [N_LED-1:0]   led_q;
    logic [TickW-1:0]   tick_q;
    logic               left_q;
    logic               running_q;
    logic               step_q;

    logic             differ, accept, arm_hit, press;
    logic             tick_max, tick_pre;
    logic             onehot;
    logic [N_LED-1:0] start_pat;
    logic [N_LED-1:0] nxt_led;
    logic             nxt_left;

    // Debounce decisions and the press pulse (only a rising accept while armed).
    always_comb begin
        differ  = sync2_q ^ deb_q;
        accept  = differ && (deb_cnt_q == DebW'(DEB_CYC - 1));
        arm_hit = !armed_q && !deb_q && !sync2_q && (arm_cnt_q == ArmW'(DEB_CYC + 1));
        press   = accept && sync2_q && armed_q;
    end

    // Synchroniser, debounce counter and the post-reset arming guard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
            armed_q   <= 1'b0;
            arm_cnt_q <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            if (accept || !differ) begin
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + DebW'(1);
            end
            if (accept) begin
                deb_q <= sync2_q;
            end
            if (armed_q || deb_q || sync2_q) begin
                arm_cnt_q <= '0;
            end else if (!arm_hit) begin
                arm_cnt_q <= arm_cnt_q + ArmW'(1);
            end
            // A held button at reset release must be seen released before it can start us.
            if (arm_hit || (accept && !sync2_q)) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Next pattern value for the current mode; non-one-hot input restarts the chase.
    always_comb begin
        tick_max  = (tick_q == TickW'(TICK_DIV - 1));
        tick_pre  = (tick_q == TickW'(TICK_DIV - 2));
        onehot    = $onehot(led_q);
        start_pat = (mode_i == 2'b01) ? {1'b1, {(N_LED - 1){1'b0}}} : N_LED'(1);
        nxt_led   = led_q;
        nxt_left  = left_q;
        unique case (mode_i)
            2'b00: nxt_led = onehot ? {led_q[N_LED-2:0], led_q[N_LED-1]} : start_pat;
            2'b01: nxt_led = onehot ? {led_q[0], led_q[N_LED-1:1]} : start_pat;
            2'b10: begin
                if (!onehot) begin
                    nxt_led  = start_pat;
                    nxt_left = 1'b1;
                end else if (left_q) begin
                    if (led_q[N_LED-1]) begin
                        nxt_left = 1'b0;
                        nxt_led  = led_q >> 1;
                    end else begin
                        nxt_led = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        nxt_left = 1'b1;
                        nxt_led  = led_q << 1;
                    end else begin
                        nxt_led = led_q >> 1;
                    end
                end
            end
            2'b11: nxt_led = (&led_q) ? N_LED'(1) : {led_q[N_LED-2:0], 1'b1};
            default: nxt_led = led_q;
        endcase
    end

    // Run/pause FSM with tick counter, pattern state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            led_q     <= '0;
            tick_q    <= '0;
            left_q    <= 1'b1;
            running_q <= 1'b0;
            step_q    <= 1'b0;
        end else if (stop_i) begin
            state_q   <= StIdle;
            led_q     <= '0;
            tick_q    <= '0;
            left_q    <= 1'b1;
            running_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    step_q <= 1'b0;
                    if (press) begin
                        state_q   <= StRun;
                        led_q     <= start_pat;
                        tick_q    <= '0;
                        left_q    <= 1'b1;
                        running_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (tick_max) begin
                        tick_q <= '0;
                        led_q  <= nxt_led;
                        left_q <= nxt_left;
                    end else begin
                        tick_q <= tick_q + TickW'(1);
                    end
                    if (press) begin
                        state_q   <= StPause;
                        running_q <= 1'b0;
                        step_q    <= 1'b0;
                    end else begin
                        running_q <= 1'b1;
                        step_q    <= tick_pre;
                    end
                end
                StPause: begin
                    if (press) begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                        // Counter was frozen; it may already sit on the last tick.
                        step_q    <= tick_max;
                    end else begin
                        step_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    led_q     <= '0;
                    tick_q    <= '0;
                    running_q <= 1'b0;
                    step_q    <= 1'b0;
                end
            endcase
        end
    end

    assign led_o     = led_q;
    assign running_o = running_q;
    assign step_o    = step_q;

endmodule

// File: doc/led_chaser.md
LED_CHASER -- requirements
Module: led_chaser

Interface
REQ-001 Parameter N_LED, default 8, number of LED outputs; legal range 2..32.
REQ-002 Parameter TICK_DIV, default 50000000, clk cycles per pattern step; legal minimum 2.
REQ-003 Parameter DEB_CYC, default 1000000, consecutive stable cycles needed to accept a button level; legal minimum 1.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 btn  input  1  raw start/pause pushbutton, asynchronous, active-high.
REQ-007 stop  input  1  synchronous stop, active-high, already synchronous to clk.
REQ-008 mode  input  2  pattern: 00 rotate-left, 01 rotate-right, 10 ping-pong, 11 fill-bar.
REQ-009 led  output  N_LED  LED drive, bit 0 = first LED.
REQ-010 running  output  1  high only in state RUN.
REQ-011 step  output  1  one-cycle pulse on each cycle where led advances.

Function
REQ-012 btn SHALL pass a 2-flop synchroniser; the debounced level SHALL update only after the synchronised level differs from it for DEB_CYC consecutive cycles; any bounce SHALL restart that count.
REQ-013 press SHALL be a one-cycle internal pulse on each 0->1 transition of the debounced level; releases SHALL generate nothing.
REQ-014 FSM states: IDLE, RUN, PAUSE; press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-015 stop SHALL force IDLE from any state on the next edge and SHALL take priority over a press in the same cycle.
REQ-016 Tick counter, 0..TICK_DIV-1: increments in RUN; wraps to 0 after TICK_DIV-1; holds in PAUSE; cleared to 0 in IDLE and on IDLE->RUN.
REQ-017 step SHALL pulse in the RUN cycle where the counter equals TICK_DIV-1; led SHALL take the next pattern value on that same edge, giving exactly one step per TICK_DIV cycles.
REQ-018 On IDLE->RUN, led SHALL load the start pattern on the same edge: mode 01 -> only bit N_LED-1 set; all other modes -> only bit 0 set; direction register SHALL be set to left.
REQ-019 Rotate-left step: bit i moves to i+1; bit N_LED-1 wraps to bit 0.
REQ-020 Rotate-right step: bit i moves to i-1; bit 0 wraps to bit N_LED-1.
REQ-021 Ping-pong step: shift one position in the current direction; at bit N_LED-1 going left, or bit 0 going right, the direction SHALL reverse and the LED SHALL move away from the end in the same step, so end LEDs are never shown twice in a row.
REQ-022 Fill-bar step: led = (led<<1)|1 until all ones; the next step from all ones SHALL give only bit 0 set.
REQ-023 A mode change SHALL take effect only at the next step, applying the new mode's rule to the current led value; if led is not one-hot when entering modes 00/01/10, the step SHALL load the start pattern of REQ-018 instead.
REQ-024 PAUSE SHALL freeze led, counter and direction; RUN after PAUSE SHALL resume with no pattern reload.
REQ-025 IDLE: led = 0, running = 0, step = 0.

Reset
REQ-026 While rst_n is low: state = IDLE, led = 0, running = 0, step = 0, counters = 0, synchroniser and debounced level = 0, direction = left.
REQ-027 Reset mid-operation SHALL abort immediately; after release the block SHALL need a fresh press to run, even if btn is held (no press until a release is debounced and a new press follows).

Verification (N_LED=4, TICK_DIV=3, DEB_CYC=2)
REQ-028 mode=00, press accepted -> led=0001, then 0010, 0100, 1000, 0001 at 3-cycle spacing, with a step pulse on each advance.
REQ-029 mode=10 -> led sequence 0001,0010,0100,1000,0100,0010,0001,0010; mode=11 -> 0001,0011,0111,1111,0001.
REQ-030 btn bounce 1,0,1,0 on single cycles then steady 1 -> exactly one press; state changes once.
REQ-031 Second press mid-run -> running=0 and led/counter frozen for 20 cycles; third press -> first step exactly TICK_DIV minus the frozen count cycles later, with the pattern continuing.
REQ-032 stop asserted with a press in the same cycle -> IDLE, led=0000; rst_n pulsed low during RUN -> led=0000 asynchronously, with btn held high after release giving no restart.
REQ-033 mode 00->01 switched with led=0100 -> next step gives 0010; switched to 10 while led=1111 (fill) -> next step gives 0001.
